// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with line refill
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache #(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_addr,
  output logic [31:0] instruction_data,
  output logic        instruction_valid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF  = $clog2(WORDS_PER_LINE);
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 30 - OFF - IDX;

  typedef enum logic [1:0] {LOOKUP, REQ, REFILL} state_t;

  state_t state, state_n;

  logic [31:2]     addr_q;
  logic            addr_q_vld;
  logic [OFF-1:0]  beat;
  logic [LINES-1:0] valid;
  logic [31:0]     data_arr [LINES][WORDS_PER_LINE];
  logic [TAGW-1:0] tag_arr  [LINES];

  logic [OFF-1:0]  word;
  logic [IDX-1:0]  idx;
  logic [TAGW-1:0] tag;
  logic            hit;
  logic            capture;
  logic            beat_wr;
  logic            refill_last;
  logic [1:0]      unused_addr_lsb;

  assign unused_addr_lsb = instruction_addr[1:0];

  assign word = addr_q[OFF+1:2];
  assign idx  = addr_q[OFF+IDX+1:OFF+2];
  assign tag  = addr_q[31:OFF+IDX+2];
  assign hit  = addr_q_vld && valid[idx] && (tag_arr[idx] == tag);

  assign beat_wr     = (state == REFILL) && mem_rvalid;
  assign refill_last = beat_wr && (beat == OFF'(WORDS_PER_LINE - 1));
  assign capture     = (state_n == LOOKUP);

  always_comb begin
    state_n           = state;
    instruction_valid = 1'b0;
    instruction_data  = '0;
    mem_req           = 1'b0;
    mem_addr          = '0;
    case (state)
      LOOKUP: begin
        if (hit) begin
          instruction_valid = 1'b1;
          instruction_data  = data_arr[idx][word];
        end else if (addr_q_vld) begin
          state_n = REQ;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:OFF+2], {(OFF+2){1'b0}}};
        if (mem_ready) state_n = REFILL;
      end
      REFILL: begin
        if (refill_last) state_n = LOOKUP;
      end
      default: state_n = LOOKUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOOKUP;
      addr_q     <= '0;
      addr_q_vld <= 1'b0;
      beat       <= '0;
      valid      <= '0;
    end else begin
      state <= state_n;
      if (capture) begin
        addr_q     <= instruction_addr[31:2];
        addr_q_vld <= 1'b1;
      end
      if (state == REQ && mem_ready) beat <= '0;
      else if (beat_wr)              beat <= beat + 1'b1;
      if (refill_last) valid[idx] <= 1'b1;
    end
  end

  // Array contents are don't-care until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (beat_wr)     data_arr[idx][beat] <= mem_rdata;
    if (refill_last) tag_arr[idx]        <= tag;
  end

`ifdef ICACHE_PERF_CNT_EN
  // fresh marks an addr_q value that has not yet been counted as a hit.
  logic fresh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      fresh      <= 1'b0;
    end else begin
      if (state == LOOKUP && hit && fresh && hit_count != '1)
        hit_count <= hit_count + 32'd1;
      if (state == LOOKUP && state_n == REQ && miss_count != '1)
        miss_count <= miss_count + 32'd1;
      if (capture)
        fresh <= !addr_q_vld || (state != LOOKUP) || (instruction_addr[31:2] != addr_q);
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_addr;
  logic [31:0] instruction_data;
  logic        instruction_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  icache dut (
    .clk              (clk),
    .reset            (reset),
    .instruction_addr (instruction_addr),
    .instruction_data (instruction_data),
    .instruction_valid(instruction_valid),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ready        (mem_ready),
    .mem_rdata        (mem_rdata),
    .mem_rvalid       (mem_rvalid)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count        (hit_count),
    .miss_count       (miss_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + i;
      step();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic miss_refill(input logic [31:0] a, input logic [31:0] base);
    instruction_addr = a;
    mem_ready        = 1'b1;
    step();
    check("mr_detect_valid", {31'd0, instruction_valid}, 32'd0);
    step();
    check("mr_req", {31'd0, mem_req}, 32'd1);
    check("mr_req_addr", mem_addr, a & 32'hFFFF_FFF0);
    step();
    check("mr_req_drop", {31'd0, mem_req}, 32'd0);
    fill(base);
    check("mr_fill_valid", {31'd0, instruction_valid}, 32'd1);
    check("mr_fill_data", instruction_data, base + ((a >> 2) & 32'd3));
  endtask

  initial begin
    reset            = 1'b0;
    instruction_addr = '0;
    mem_ready        = 1'b0;
    mem_rdata        = '0;
    mem_rvalid       = 1'b0;
    step();
    step();
    check("rst_valid", {31'd0, instruction_valid}, 32'd0);
    check("rst_data", instruction_data, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);

    // Cold miss: valid first appears after the 7th edge (WORDS_PER_LINE+3).
    reset            = 1'b1;
    instruction_addr = 32'h100;
    mem_ready        = 1'b1;
    step();
    check("cold_detect_valid", {31'd0, instruction_valid}, 32'd0);
    check("cold_detect_req", {31'd0, mem_req}, 32'd0);
    step();
    check("cold_req", {31'd0, mem_req}, 32'd1);
    check("cold_req_addr", mem_addr, 32'h100);
    step();
    check("cold_req_drop", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA0; step();
    mem_rdata  = 32'hA1; step();
    mem_rdata  = 32'hA2; step();
    check("cold_early_valid", {31'd0, instruction_valid}, 32'd0);
    check("cold_early_data", instruction_data, 32'd0);
    mem_rdata  = 32'hA3; step();
    mem_rvalid = 1'b0;
    check("cold_valid", {31'd0, instruction_valid}, 32'd1);
    check("cold_data", instruction_data, 32'hA0);

    // Hits on the freshly filled line, one per cycle.
    for (int i = 1; i < 4; i++) begin
      instruction_addr = 32'h100 + 4 * i;
      step();
      check("hit_valid", {31'd0, instruction_valid}, 32'd1);
      check("hit_data", instruction_data, 32'hA0 + i);
      check("hit_no_req", {31'd0, mem_req}, 32'd0);
    end

    // Conflict eviction, then re-fetch 0x100 under backpressure.
    miss_refill(32'h500, 32'hB0);
    instruction_addr = 32'h100;
    mem_ready        = 1'b0;
    step();
    check("evict_refetch_miss", {31'd0, instruction_valid}, 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD;
      check("bp_req_held", {31'd0, mem_req}, 32'd1);
      check("bp_addr_held", mem_addr, 32'h100);
      step();
    end
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    check("bp_req_final", {31'd0, mem_req}, 32'd1);
    step();
    check("bp_one_accept", {31'd0, mem_req}, 32'd0);
    fill(32'hC0);
    check("bp_fill_valid", {31'd0, instruction_valid}, 32'd1);
    check("bp_fill_data", instruction_data, 32'hC0);
    instruction_addr = 32'h104;
    step();
    check("bp_hit_word1", instruction_data, 32'hC1);

    // Jump mid-refill: 0x100 line completes, then 0x200 misses.
    miss_refill(32'h500, 32'hE0);
    instruction_addr = 32'h100;
    step();
    check("jump_miss", {31'd0, instruction_valid}, 32'd0);
    step();
    check("jump_req_addr", mem_addr, 32'h100);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hD0; step();
    mem_rdata  = 32'hD1; step();
    instruction_addr = 32'h200;
    mem_rdata  = 32'hD2; step();
    mem_rdata  = 32'hD3; step();
    mem_rvalid = 1'b0;
    check("jump_new_miss", {31'd0, instruction_valid}, 32'd0);
    step();
    check("jump_req2", {31'd0, mem_req}, 32'd1);
    check("jump_req2_addr", mem_addr, 32'h200);
    step();
    fill(32'hF0);
    check("jump_fill_data", instruction_data, 32'hF0);
    instruction_addr = 32'h108;
    step();
    check("jump_old_valid", {31'd0, instruction_valid}, 32'd1);
    check("jump_old_data", instruction_data, 32'hD2);

    // Reset after beat 2 of a refill.
    instruction_addr = 32'h500;
    step();
    step();
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h60; step();
    mem_rdata  = 32'h61; step();
    mem_rdata  = 32'h62; step();
    mem_rdata  = 32'h63;
    reset      = 1'b0;
    #1;
    check("mrst_req", {31'd0, mem_req}, 32'd0);
    check("mrst_addr", mem_addr, 32'd0);
    check("mrst_valid", {31'd0, instruction_valid}, 32'd0);
    check("mrst_data", instruction_data, 32'd0);
    step();
    reset            = 1'b1;
    instruction_addr = 32'h100;
    mem_rdata        = 32'h5757;
    step();
    mem_rvalid = 1'b0;
    check("mrst_refetch_miss", {31'd0, instruction_valid}, 32'd0);
    check("mrst_no_req_yet", {31'd0, mem_req}, 32'd0);
    step();
    check("mrst_req2", {31'd0, mem_req}, 32'd1);
    check("mrst_req2_addr", mem_addr, 32'h100);
    step();
    fill(32'h70);
    check("mrst_fill_data", instruction_data, 32'h70);
    instruction_addr = 32'h200;
    step();
    check("mrst_cleared_200", {31'd0, instruction_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
Direct-mapped, read-only instruction cache sitting directly upstream of the core's fetch port. Serves the core's instruction_addr / instruction_data / instruction_valid interface. Refills whole lines from a backing instruction memory over a request/beat handshake. Holds no dirty state and never writes back.

Parameters:
LINES, 64, number of cache lines; power of two, at least 2.
WORDS_PER_LINE, 4, 32-bit words per line; power of two, at least 2.

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  asynchronous, active-low reset.
instruction_addr  in  32  fetch byte address from the core; bits [1:0] are ignored.
instruction_data  out  32  instruction word for addr_q.
instruction_valid  out  1  instruction_data is valid for addr_q.
mem_req  out  1  line refill request.
mem_addr  out  32  line-aligned byte address of the refill.
mem_ready  in  1  backing memory accepts the request.
mem_rdata  in  32  refill beat data.
mem_rvalid  in  1  refill beat valid.

Behaviour:
- Address split: OFF = log2(WORDS_PER_LINE), IDX = log2(LINES).
  - Word select: a[OFF+1:2].
  - Index: a[OFF+IDX+1:OFF+2].
  - Tag: a[31:OFF+IDX+2].
- Storage: data array, tag array and per-line valid bits, all flop-based with combinational read from addr_q.
- addr_q / addr_q_vld:
  - addr_q captures instruction_addr on every rising edge where next_state is LOOKUP.
  - addr_q_vld is 0 after reset and set on the first capture.
- hit = addr_q_vld and valid[idx] and tag[idx] == tag(addr_q).
- State LOOKUP:
  - instruction_valid = hit; instruction_data = data[idx][word].
  - On a miss with addr_q_vld = 1: go to REQ, freeze addr_q, instruction_valid = 0.
- State REQ:
  - mem_req = 1; mem_addr = addr_q with bits [OFF+1:0] cleared.
  - Stay while mem_ready = 0; mem_addr is held stable.
  - On mem_req and mem_ready: clear beat counter to 0, go to REFILL.
  - mem_req drops in the cycle after acceptance.
- State REFILL:
  - Each mem_rvalid writes mem_rdata into data[idx][beat], then beat increments.
  - Beats arrive in ascending word order.
  - On the beat where beat == WORDS_PER_LINE-1: write tag[idx], set valid[idx], go to LOOKUP.
  - On that same edge addr_q recaptures instruction_addr.
- Outputs outside LOOKUP: instruction_valid = 0 and instruction_data = 0 in REQ and REFILL, and whenever instruction_valid = 0.
- Latency: a hit is valid the cycle after the address is presented.
  - Miss penalty = 1 detect cycle + REQ wait cycles + WORDS_PER_LINE beat cycles (minimum) + 1 lookup cycle.
- Core protocol: the core holds instruction_addr until it sees valid.
  - If the address changes (jump), the new address is captured on the next LOOKUP edge.
  - An in-flight refill is never aborted; it completes and installs its line, then the new address is looked up.
- Replacement: a refill overwrites the line at its index unconditionally (conflict eviction).
- Ignored inputs: mem_rvalid in LOOKUP or REQ, and mem_ready outside REQ.
- Reset (asserted any time, including mid-refill):
  - Immediately forces state LOOKUP, all valid bits 0, addr_q_vld 0, beat 0.
  - Outputs: mem_req 0, mem_addr 0, instruction_valid 0, instruction_data 0.
  - Beats arriving after deassertion while in LOOKUP are ignored.
  - Data and tag arrays need not be reset.

Optional Feature:
ICACHE_PERF_CNT_EN:
- When defined, adds outputs hit_count (32) and miss_count (32). Both reset to 0 and saturate at 0xFFFFFFFF.
  - hit_count increments for each distinct capture of addr_q that hits, counting once per captured address (not per idle cycle).
  - miss_count increments on each LOOKUP→REQ transition.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, instruction_addr=0x100, mem_ready=1, beats 0xA0..0xA3 on consecutive cycles.
  - mem_req is 1 with mem_addr=0x100.
  - Then instruction_valid=1, instruction_data=0xA0, exactly WORDS_PER_LINE+3 cycles after the address is first sampled.
- Hit after fill: step instruction_addr through 0x104, 0x108, 0x10C, one per cycle.
  - Data is 0xA1, 0xA2, 0xA3 with valid every cycle and mem_req stays 0.
- Conflict eviction: with 0x100 resident, fetch 0x100 + LINES*WORDS_PER_LINE*4 (0x500 with defaults).
  - A refill occurs; re-fetching 0x100 misses again (miss_count +2 when ICACHE_PERF_CNT_EN is defined).
- Backpressure: hold mem_ready=0 for 5 cycles.
  - mem_req and mem_addr are held stable; exactly one request is accepted; no beats are consumed before acceptance.
- Jump mid-refill: change instruction_addr to 0x200 after beat 1.
  - The 0x100 line completes and is valid, then 0x200 misses and refills.
- Reset mid-refill: assert reset after beat 2, release, fetch 0x100.
  - Full miss: mem_req asserted, valid bits cleared, late stray mem_rvalid ignored.
